status_led_ctrl: RTL and testbench

STATUS_LED_CTRL -- requirements
Module: status_led_ctrl

---
 rtl/status_led_pkg.sv | 19 +
 rtl/status_led_if.sv | 24 ++
 rtl/led_channel.sv | 71 +++++++
 rtl/status_led_ctrl.sv | 68 ++++++
 tb/tb_status_led_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/status_led_pkg.sv
// Shared types and constants for the status LED controller.
// Mode encoding per channel plus a counter width helper.
package status_led_pkg;

  typedef enum logic [1:0] {
    LED_OFF     = 2'd0,
    LED_DIRECT  = 2'd1,
    LED_STRETCH = 2'd2,
    LED_TOGGLE  = 2'd3
  } led_mode_t;

  localparam int unsigned RST_SYNC_STAGES = 2;

  // Counter width for a terminal value n, never less than one bit.
  function automatic int unsigned ctr_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/status_led_if.sv
// Event/mode inputs and LED/counter outputs of the status LED controller.
interface status_led_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 32
) ();

  logic [NUM_CH-1:0]       event_in;
  logic [2*NUM_CH-1:0]     mode;
  logic                    cnt_clr;
  logic [NUM_CH-1:0]       led;
  logic                    heartbeat;
  logic [NUM_CH*CNT_W-1:0] event_cnt;

  modport master (
    output event_in, mode, cnt_clr,
    input  led, heartbeat, event_cnt
  );

  modport slave (
    input  event_in, mode, cnt_clr,
    output led, heartbeat, event_cnt
  );

endinterface

// File: rtl/led_channel.sv
// One LED channel: rising-edge detect, stretch timer, toggle state and
// saturating event counter, all with registered outputs.
module led_channel
  import status_led_pkg::*;
#(
  parameter int unsigned STRETCH_CYCLES = 12500000,
  parameter int unsigned CNT_W          = 32
) (
  input  logic             clk_125mhz,
  input  logic             rst_n,
  input  logic             event_in,
  input  led_mode_t        mode,
  input  logic             cnt_clr,
  output logic             led,
  output logic [CNT_W-1:0] event_cnt
);

  localparam int unsigned      TMR_W    = ctr_width(STRETCH_CYCLES);
  // Timer holds remaining high clocks after the first one, so it never needs STRETCH_CYCLES itself.
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(STRETCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic             prev_q;
  logic [TMR_W-1:0] tmr_q;
  logic             tog_q;
  logic             rise_c;

  assign rise_c = event_in & ~prev_q;

  always_ff @(posedge clk_125mhz or negedge rst_n) begin
    if (!rst_n) begin
      prev_q    <= 1'b0;
      tmr_q     <= '0;
      tog_q     <= 1'b0;
      led       <= 1'b0;
      event_cnt <= '0;
    end else begin
      prev_q <= event_in;

      if (mode != LED_STRETCH) begin
        tmr_q <= '0;
      end else if (rise_c) begin
        tmr_q <= TMR_LOAD;
      end else if (tmr_q != '0) begin
        tmr_q <= tmr_q - TMR_W'(1);
      end

      if (mode != LED_TOGGLE) begin
        tog_q <= 1'b0;
      end else begin
        tog_q <= tog_q ^ rise_c;
      end

      case (mode)
        LED_OFF:     led <= 1'b0;
        LED_DIRECT:  led <= event_in;
        LED_STRETCH: led <= rise_c | (tmr_q != '0);
        LED_TOGGLE:  led <= tog_q ^ rise_c;
        default:     led <= 1'b0;
      endcase

      // Clear wins over a coincident edge.
      if (cnt_clr) begin
        event_cnt <= '0;
      end else if (rise_c && (event_cnt != CNT_MAX)) begin
        event_cnt <= event_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/status_led_ctrl.sv
// Multi-channel status LED controller: reset synchroniser, heartbeat blinker
// and one led_channel per event input.
module status_led_ctrl
  import status_led_pkg::*;
#(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned STRETCH_CYCLES = 12500000,
  parameter int unsigned HB_HALF_CYCLES = 62500000,
  parameter int unsigned CNT_W          = 32
) (
  input  logic        clk_125mhz,
  input  logic        rst_n,
  status_led_if.slave bus
);

  localparam int unsigned   HB_W    = ctr_width(HB_HALF_CYCLES);
  localparam logic [HB_W-1:0] HB_LAST = HB_W'(HB_HALF_CYCLES - 1);

  logic [RST_SYNC_STAGES-1:0] rst_sync_q;
  logic                       rst_int_n;
  logic [HB_W-1:0]            hb_cnt_q;
  logic                       heartbeat_q;
  logic [NUM_CH-1:0]          led_w;
  logic [NUM_CH*CNT_W-1:0]    cnt_w;

  // Assert asynchronously, release after RST_SYNC_STAGES clock edges.
  always_ff @(posedge clk_125mhz or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= '0;
    end else begin
      rst_sync_q <= {rst_sync_q[RST_SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign rst_int_n = rst_sync_q[RST_SYNC_STAGES-1];

  always_ff @(posedge clk_125mhz or negedge rst_int_n) begin
    if (!rst_int_n) begin
      hb_cnt_q    <= '0;
      heartbeat_q <= 1'b0;
    end else if (hb_cnt_q == HB_LAST) begin
      hb_cnt_q    <= '0;
      heartbeat_q <= ~heartbeat_q;
    end else begin
      hb_cnt_q    <= hb_cnt_q + HB_W'(1);
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    led_channel #(
      .STRETCH_CYCLES (STRETCH_CYCLES),
      .CNT_W          (CNT_W)
    ) u_ch (
      .clk_125mhz (clk_125mhz),
      .rst_n      (rst_int_n),
      .event_in   (bus.event_in[i]),
      .mode       (led_mode_t'(bus.mode[2*i +: 2])),
      .cnt_clr    (bus.cnt_clr),
      .led        (led_w[i]),
      .event_cnt  (cnt_w[i*CNT_W +: CNT_W])
    );
  end

  assign bus.led       = led_w;
  assign bus.heartbeat = heartbeat_q;
  assign bus.event_cnt = cnt_w;

endmodule

// File: tb/tb_status_led_ctrl.sv
// Bench for status_led_ctrl: directed scenarios plus a randomized run
// checked against a cycle-indexed behavioural model.
module tb_status_led_ctrl;

  localparam int NCH     = 4;
  localparam int STRETCH = 8;
  localparam int HB_HALF = 16;
  localparam int CW      = 4;
  localparam int CMAX    = 15;

  logic clk_125mhz;
  logic rst_n;
  int   checks;
  int   errors;

  status_led_if #(.NUM_CH(NCH), .CNT_W(CW)) bus ();

  status_led_ctrl #(
    .NUM_CH         (NCH),
    .STRETCH_CYCLES (STRETCH),
    .HB_HALF_CYCLES (HB_HALF),
    .CNT_W          (CW)
  ) dut (
    .clk_125mhz (clk_125mhz),
    .rst_n      (rst_n),
    .bus        (bus)
  );

  initial clk_125mhz = 1'b0;
  always #4 clk_125mhz = ~clk_125mhz;

  // Model: stretch is "latest edge seen in stretch mode less than STRETCH clocks ago",
  // toggle is parity of edges since entering toggle mode.
  int m_cyc;
  int m_last_edge [NCH];
  int m_edges_tog [NCH];
  int m_cnt       [NCH];
  bit m_prev      [NCH];
  bit m_led       [NCH];

  task automatic model_reset();
    m_cyc = 0;
    for (int ch = 0; ch < NCH; ch++) begin
      m_last_edge[ch] = -1000;
      m_edges_tog[ch] = 0;
      m_cnt[ch]       = 0;
      m_prev[ch]      = 1'b0;
      m_led[ch]       = 1'b0;
    end
  endtask

  task automatic model_step(input logic [NCH-1:0] ev, input logic [2*NCH-1:0] md, input logic clr);
    for (int ch = 0; ch < NCH; ch++) begin
      bit e;
      int mm;
      e  = ev[ch] && !m_prev[ch];
      mm = int'(md[2*ch +: 2]);
      if (mm == 2) begin
        if (e) m_last_edge[ch] = m_cyc;
      end else begin
        m_last_edge[ch] = -1000;
      end
      if (mm == 3) m_edges_tog[ch] += int'(e);
      else         m_edges_tog[ch] = 0;
      case (mm)
        0:       m_led[ch] = 1'b0;
        1:       m_led[ch] = ev[ch];
        2:       m_led[ch] = (m_last_edge[ch] >= 0) && (m_cyc - m_last_edge[ch] < STRETCH);
        default: m_led[ch] = (m_edges_tog[ch] % 2) == 1;
      endcase
      if (clr)                  m_cnt[ch] = 0;
      else if (e && m_cnt[ch] < CMAX) m_cnt[ch] = m_cnt[ch] + 1;
      m_prev[ch] = ev[ch];
    end
    m_cyc++;
  endtask

  // Drive one clock of inputs, advance the model, sample 1 time unit after the edge.
  task automatic step(input logic [NCH-1:0] ev, input logic [2*NCH-1:0] md, input logic clr);
    bus.event_in = ev;
    bus.mode     = md;
    bus.cnt_clr  = clr;
    model_step(ev, md, clr);
    @(posedge clk_125mhz);
    #1;
  endtask

  task automatic settle(input logic [2*NCH-1:0] md);
    repeat (10) step('0, md, 1'b1);
  endtask

  task automatic test_reset();
    bus.event_in = '0;
    bus.mode     = '0;
    bus.cnt_clr  = 1'b0;
    rst_n        = 1'b0;
    repeat (2) @(posedge clk_125mhz);
    #1;
    checks++; if (bus.led !== 4'h0) begin errors++; $display("FAIL reset_led got %0h want 0", bus.led); end
    checks++; if (bus.heartbeat !== 1'b0) begin errors++; $display("FAIL reset_hb got %0b want 0", bus.heartbeat); end
    checks++; if (bus.event_cnt !== 16'h0) begin errors++; $display("FAIL reset_cnt got %0h want 0", bus.event_cnt); end
    rst_n = 1'b1;
    repeat (3) @(posedge clk_125mhz);
    #1;
    model_reset();
  endtask

  task automatic test_heartbeat();
    bit exp;
    rst_n = 1'b0;
    repeat (2) @(posedge clk_125mhz);
    #1;
    rst_n = 1'b1;
    for (int k = 1; k <= 72; k++) begin
      @(posedge clk_125mhz);
      #1;
      exp = (k < 2) ? 1'b0 : (((k - 2) / HB_HALF) % 2 == 1);
      checks++;
      if (bus.heartbeat !== exp) begin
        errors++;
        $display("FAIL heartbeat edge %0d got %0b want %0b", k, bus.heartbeat, exp);
      end
    end
    model_reset();
  endtask

  task automatic test_stretch();
    logic [7:0] md;
    bit exp;
    md = 8'b00_00_00_10;
    settle(md);
    for (int i = 0; i <= 9; i++) begin
      step((i == 0) ? 4'b0001 : 4'b0000, md, 1'b0);
      exp = (i + 1) <= STRETCH;
      checks++;
      if (bus.led[0] !== exp) begin
        errors++;
        $display("FAIL stretch T+%0d got %0b want %0b", i + 1, bus.led[0], exp);
      end
    end
    checks++;
    if (bus.event_cnt[3:0] !== 4'd1) begin errors++; $display("FAIL stretch_cnt got %0d want 1", bus.event_cnt[3:0]); end
  endtask

  task automatic test_retrigger();
    logic [7:0] md;
    bit exp;
    md = 8'b00_00_00_10;
    settle(md);
    for (int i = 0; i <= 14; i++) begin
      step((i == 0 || i == 5) ? 4'b0001 : 4'b0000, md, 1'b0);
      exp = (i + 1) <= 13;
      checks++;
      if (bus.led[0] !== exp) begin
        errors++;
        $display("FAIL retrigger T+%0d got %0b want %0b", i + 1, bus.led[0], exp);
      end
    end
    checks++;
    if (bus.event_cnt[3:0] !== 4'd2) begin errors++; $display("FAIL retrigger_cnt got %0d want 2", bus.event_cnt[3:0]); end
  endtask

  task automatic test_direct_toggle_off();
    logic [7:0] md;
    logic [3:0] ev;
    int pulses;
    md = 8'b00_11_01_00;
    settle(md);
    pulses = 0;
    for (int i = 0; i <= 8; i++) begin
      ev = (i % 3 == 0) ? 4'hF : 4'h0;
      if (ev != 4'h0) pulses++;
      step(ev, md, 1'b0);
      checks++;
      if (bus.led[1] !== ev[1]) begin errors++; $display("FAIL direct step %0d got %0b want %0b", i, bus.led[1], ev[1]); end
      checks++;
      if (bus.led[2] !== ((pulses % 2) == 1)) begin
        errors++; $display("FAIL toggle step %0d got %0b want %0b", i, bus.led[2], (pulses % 2) == 1);
      end
      checks++;
      if (bus.led[3] !== 1'b0) begin errors++; $display("FAIL off step %0d got %0b want 0", i, bus.led[3]); end
    end
    for (int ch = 0; ch < NCH; ch++) begin
      checks++;
      if (bus.event_cnt[ch*CW +: CW] !== 4'd3) begin
        errors++; $display("FAIL dto_cnt ch%0d got %0d want 3", ch, bus.event_cnt[ch*CW +: CW]);
      end
    end
  endtask

  task automatic test_saturation_clear();
    logic [7:0] md;
    md = 8'h00;
    settle(md);
    for (int p = 0; p < 20; p++) begin
      step(4'b0001, md, 1'b0);
      step(4'b0000, md, 1'b0);
      if (p == 9) begin
        checks++;
        if (bus.event_cnt[3:0] !== 4'd10) begin errors++; $display("FAIL sat_mid got %0d want 10", bus.event_cnt[3:0]); end
      end
    end
    checks++;
    if (bus.event_cnt[3:0] !== 4'd15) begin errors++; $display("FAIL sat_max got %0d want 15", bus.event_cnt[3:0]); end
    step(4'b0001, md, 1'b1);
    checks++;
    if (bus.event_cnt[3:0] !== 4'd0) begin errors++; $display("FAIL clr_priority got %0d want 0", bus.event_cnt[3:0]); end
    step(4'b0000, md, 1'b0);
    step(4'b0001, md, 1'b0);
    checks++;
    if (bus.event_cnt[3:0] !== 4'd1) begin errors++; $display("FAIL post_clr got %0d want 1", bus.event_cnt[3:0]); end
  endtask

  task automatic test_reset_mid_stretch();
    logic [7:0] md;
    md = 8'b00_00_00_10;
    settle(md);
    step(4'b0001, md, 1'b0);
    step(4'b0000, md, 1'b0);
    step(4'b0000, md, 1'b0);
    checks++;
    if (bus.led[0] !== 1'b1) begin errors++; $display("FAIL pre_rst_led got %0b want 1", bus.led[0]); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.led !== 4'h0) begin errors++; $display("FAIL async_rst_led got %0h want 0", bus.led); end
    checks++;
    if (bus.event_cnt !== 16'h0) begin errors++; $display("FAIL async_rst_cnt got %0h want 0", bus.event_cnt); end
    repeat (2) @(posedge clk_125mhz);
    #1;
    rst_n = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      @(posedge clk_125mhz);
      #1;
      checks++;
      if (bus.led !== 4'h0 || bus.heartbeat !== 1'b0) begin
        errors++; $display("FAIL rst_release edge %0d got led %0h hb %0b want 0 0", k, bus.led, bus.heartbeat);
      end
    end
    model_reset();
    for (int k = 0; k < 10; k++) begin
      step(4'b0000, md, 1'b0);
      checks++;
      if (bus.led[0] !== 1'b0 || bus.event_cnt[3:0] !== 4'd0) begin
        errors++; $display("FAIL idle_after_rst k=%0d got led %0b cnt %0d want 0 0", k, bus.led[0], bus.event_cnt[3:0]);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0]  md;
    logic [3:0]  ev;
    logic        clr;
    logic [3:0]  exp_led;
    logic [15:0] exp_cnt;
    rst_n = 1'b0;
    bus.event_in = '0;
    bus.mode     = '0;
    bus.cnt_clr  = 1'b0;
    repeat (2) @(posedge clk_125mhz);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk_125mhz);
    #1;
    model_reset();
    md = 8'($urandom);
    ev = 4'h0;
    for (int c = 0; c < 500; c++) begin
      for (int ch = 0; ch < NCH; ch++) begin
        if ($urandom_range(15) == 0) md[2*ch +: 2] = 2'($urandom_range(3));
        if ($urandom_range(2) == 0)  ev[ch] = ~ev[ch];
      end
      clr = ($urandom_range(31) == 0);
      step(ev, md, clr);
      for (int ch = 0; ch < NCH; ch++) begin
        exp_led[ch]          = m_led[ch];
        exp_cnt[ch*CW +: CW] = 4'(m_cnt[ch]);
      end
      checks++;
      if (bus.led !== exp_led) begin
        errors++; $display("FAIL rand_led cyc %0d got %0h want %0h", c, bus.led, exp_led);
      end
      checks++;
      if (bus.event_cnt !== exp_cnt) begin
        errors++; $display("FAIL rand_cnt cyc %0d got %0h want %0h", c, bus.event_cnt, exp_cnt);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    model_reset();
    test_reset();
    test_heartbeat();
    test_stretch();
    test_retrigger();
    test_direct_toggle_off();
    test_saturation_clear();
    test_reset_mid_stretch();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
